// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   - funct3 access-size codes
//   - FSM state encoding
//   - access_err(): decides whether a request is misaligned or illegal
package lsu_ctrl_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMerge,
    StWrite,
    StResp
  } lsu_state_e;

  // Returns 1 when the request must be rejected without touching memory.
  // Unsigned variants only exist for loads, so a store with funct3[2] set is illegal.
  function automatic logic access_err(input logic [2:0] f3, input logic write,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    case (f3)
      Funct3B:  err = 1'b0;
      Funct3H:  err = addr_lo[0];
      Funct3W:  err = |addr_lo;
      Funct3Bu: err = write;
      Funct3Hu: err = write | addr_lo[0];
      default:  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment logic for the load/store unit.
// Ports:
//   chk_funct3, chk_write, chk_addr_lo  - request being offered (for error detection)
//   chk_err                             - request is misaligned or illegal
//   funct3, addr_lo                     - latched request driving the data path
//   wdata_lo                            - low half of latched store data
//   mem_rdata                           - current memory word
//   load_data                           - selected lane, sign/zero extended
//   merge_data                          - memory word with the store lane replaced
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [2:0]    chk_funct3,
  input  logic          chk_write,
  input  logic [1:0]    chk_addr_lo,
  output logic          chk_err,
  input  logic [2:0]    funct3,
  input  logic [1:0]    addr_lo,
  input  logic [15:0]   wdata_lo,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] load_data,
  output logic [DW-1:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign chk_err = access_err(chk_funct3, chk_write, chk_addr_lo);

  // Little-endian lane select.
  always_comb begin
    lane_b = 8'h00;
    unique case (addr_lo)
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      Funct3B:  load_data = {{24{lane_b[7]}}, lane_b};
      Funct3H:  load_data = {{16{lane_h[15]}}, lane_h};
      Funct3W:  load_data = mem_rdata;
      Funct3Bu: load_data = {24'h000000, lane_b};
      Funct3Hu: load_data = {16'h0000, lane_h};
      default:  load_data = '0;
    endcase
  end

  // Only SB/SH reach the merge path; funct3[0] separates half from byte.
  always_comb begin
    merge_data = mem_rdata;
    if (funct3[0]) begin
      if (addr_lo[1]) merge_data[31:16] = wdata_lo;
      else            merge_data[15:0]  = wdata_lo;
    end else begin
      unique case (addr_lo)
        2'd0: merge_data[7:0]   = wdata_lo[7:0];
        2'd1: merge_data[15:8]  = wdata_lo[7:0];
        2'd2: merge_data[23:16] = wdata_lo[7:0];
        2'd3: merge_data[31:24] = wdata_lo[7:0];
        default: merge_data = mem_rdata;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between the EX/MEM stage and the word-wide data memory.
// One request per handshake; sub-word stores are read-modify-write.
// Ports:
//   CLK, RST          - clock (rising edge) and asynchronous active-high reset
//   req_valid/ready   - request handshake; ready only while idle
//   req_write, funct3 - store flag and access size
//   addr, wdata       - byte address and right-justified store data
//   resp_valid        - one-cycle completion pulse
//   rdata, ls_err     - extended load data and error flag, valid with resp_valid
//   mem_addr          - word-aligned address to the memory
//   mem_wdata, mem_we - write data and write enable to the memory
//   mem_rdata         - combinational read data from the memory
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          resp_valid,
  output logic [DW-1:0] rdata,
  output logic          ls_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_e    state_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    funct3_q;
  logic [15:0]   wdata_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          ls_err_q;

  logic          chk_err;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merge_data;

  lsu_align #(
    .DW (DW)
  ) u_align (
    .chk_funct3  (funct3),
    .chk_write   (req_write),
    .chk_addr_lo (addr[1:0]),
    .chk_err     (chk_err),
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .wdata_lo    (wdata_q),
    .mem_rdata   (mem_rdata),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      funct3_q    <= 3'b000;
      wdata_q     <= 16'h0000;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q      <= addr;
            funct3_q    <= funct3;
            wdata_q     <= wdata[15:0];
            // SW writes wdata as-is; SB/SH overwrite this in MERGE.
            mem_wdata_q <= wdata;
            rdata_q     <= '0;
            ls_err_q    <= chk_err;
            if (chk_err)                   state_q <= StResp;
            else if (!req_write)           state_q <= StLoad;
            else if (funct3[1:0] == 2'b10) state_q <= StWrite;
            else                           state_q <= StMerge;
          end
        end
        StLoad: begin
          rdata_q <= load_data;
          state_q <= StResp;
        end
        StMerge: begin
          mem_wdata_q <= merge_data;
          state_q     <= StWrite;
        end
        StWrite: state_q <= StResp;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decoded from the state register so an asynchronous reset drops them at once.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign mem_we     = (state_q == StWrite);

  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ls_err    = ls_err_q;

endmodule
